// File: rtl/i8088_bus_master_if.sv
// Command port plus multiplexed 8088 bus signals for the bus-cycle initiator.
// The master modport is the initiator's view; slave is the requester/responder side.
interface i8088_bus_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_io;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        ALE;
  logic [11:0] A;
  logic [7:0]  AD_O;
  logic        AD_OE;
  logic [7:0]  AD_I;
  logic        IOM;
  logic        DTR;
  logic        DEN;
  logic        RD;
  logic        WR;
  logic        READY;

  modport master (
    input  req_valid, req_write, req_io, req_addr, req_wdata, AD_I, READY,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output ALE, A, AD_O, AD_OE, IOM, DTR, DEN, RD, WR
  );

  modport slave (
    output req_valid, req_write, req_io, req_addr, req_wdata, AD_I, READY,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  ALE, A, AD_O, AD_OE, IOM, DTR, DEN, RD, WR
  );
endinterface

// File: rtl/i8088_bus_master.sv
// Minimum-mode 8088 bus-cycle initiator: one command -> T1..T4 (+TW while READY low), rsp_valid in T4, 4 clocks minimum.
// req_ready only in IDLE/T4; define BUS_TIMEOUT_EN to bound wait states at WAIT_LIMIT and flag rsp_err.
module i8088_bus_master #(
  parameter int WAIT_LIMIT = 15
) (
  input logic                CLK,
  input logic                RESET,
  i8088_bus_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, T1, T2, T3, TW, T4} state_t;

  state_t      state, state_n;
  logic [19:0] addr_q, addr_n;
  logic [7:0]  wdata_q, wdata_n;
  logic        write_q, write_n;
  logic        io_q, io_n;

  logic        req_ready_q, req_ready_n;
  logic        rsp_valid_q, rsp_valid_n;
  logic [7:0]  rsp_rdata_q, rsp_rdata_n;
  logic        ale_q, ale_n;
  logic [11:0] a_q, a_n;
  logic [7:0]  ad_o_q, ad_o_n;
  logic        ad_oe_q, ad_oe_n;
  logic        iom_q, iom_n;
  logic        dtr_q, dtr_n;
  logic        den_q, den_n;
  logic        rd_q, rd_n;
  logic        wr_q, wr_n;

  logic        accept;
  assign accept = bus.req_valid & req_ready_q;

`ifdef BUS_TIMEOUT_EN
  localparam int CW = (WAIT_LIMIT > 15) ? $clog2(WAIT_LIMIT + 1) : 4;
  logic [CW-1:0] wait_cnt_q, wait_cnt_n;
  logic          err_q, err_n;
  logic          timeout;
`endif

  always_comb begin
    state_n     = state;
    addr_n      = addr_q;
    wdata_n     = wdata_q;
    write_n     = write_q;
    io_n        = io_q;
    rsp_rdata_n = rsp_rdata_q;
    a_n         = a_q;
    ad_o_n      = ad_o_q;
    iom_n       = iom_q;
    dtr_n       = dtr_q;
    ale_n       = 1'b0;
    ad_oe_n     = 1'b0;
    den_n       = 1'b1;
    rd_n        = 1'b1;
    wr_n        = 1'b1;
    req_ready_n = 1'b0;
    rsp_valid_n = 1'b0;
`ifdef BUS_TIMEOUT_EN
    wait_cnt_n  = wait_cnt_q;
    err_n       = err_q;
    timeout     = 1'b0;
`endif

    if (accept) begin
      // I/O space only decodes 16 bits; keep the upper nibble quiet on the bus.
      addr_n  = bus.req_io ? {4'h0, bus.req_addr[15:0]} : bus.req_addr;
      wdata_n = bus.req_wdata;
      write_n = bus.req_write;
      io_n    = bus.req_io;
`ifdef BUS_TIMEOUT_EN
      err_n   = 1'b0;
`endif
    end

    case (state)
      IDLE:    if (accept) state_n = T1;
      T4:      state_n = accept ? T1 : IDLE;
      T1:      state_n = T2;
      T2:      state_n = T3;
      T3, TW: begin
        if (bus.READY) begin
          state_n = T4;
        end else begin
`ifdef BUS_TIMEOUT_EN
          if (wait_cnt_q == CW'(WAIT_LIMIT)) begin
            state_n = T4;
            timeout = 1'b1;
            err_n   = 1'b1;
          end else begin
            state_n = TW;
          end
`else
          state_n = TW;
`endif
        end
      end
      default: state_n = IDLE;
    endcase

`ifdef BUS_TIMEOUT_EN
    if (state == T2)
      wait_cnt_n = '0;
    else if (state_n == TW)
      wait_cnt_n = wait_cnt_q + 1'b1;
`endif

    if ((state == T3 || state == TW) && state_n == T4 && !write_q) begin
      rsp_rdata_n = bus.AD_I;
`ifdef BUS_TIMEOUT_EN
      if (timeout) rsp_rdata_n = 8'hFF;
`endif
    end

    // Outputs are decoded from the next state so they register in step with it.
    case (state_n)
      IDLE: req_ready_n = 1'b1;
      T1: begin
        ale_n   = 1'b1;
        a_n     = addr_n[19:8];
        ad_o_n  = addr_n[7:0];
        ad_oe_n = 1'b1;
        iom_n   = io_n;
        dtr_n   = write_n;
      end
      T2, T3, TW: begin
        den_n = 1'b0;
        if (write_n) begin
          ad_o_n  = wdata_n;
          ad_oe_n = 1'b1;
          wr_n    = 1'b0;
          dtr_n   = 1'b1;
        end else begin
          rd_n  = 1'b0;
          dtr_n = 1'b0;
        end
      end
      T4: begin
        req_ready_n = 1'b1;
        rsp_valid_n = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      io_q        <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      ale_q       <= 1'b0;
      a_q         <= '0;
      ad_o_q      <= '0;
      ad_oe_q     <= 1'b0;
      iom_q       <= 1'b0;
      dtr_q       <= 1'b1;
      den_q       <= 1'b1;
      rd_q        <= 1'b1;
      wr_q        <= 1'b1;
`ifdef BUS_TIMEOUT_EN
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      addr_q      <= addr_n;
      wdata_q     <= wdata_n;
      write_q     <= write_n;
      io_q        <= io_n;
      req_ready_q <= req_ready_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_rdata_q <= rsp_rdata_n;
      ale_q       <= ale_n;
      a_q         <= a_n;
      ad_o_q      <= ad_o_n;
      ad_oe_q     <= ad_oe_n;
      iom_q       <= iom_n;
      dtr_q       <= dtr_n;
      den_q       <= den_n;
      rd_q        <= rd_n;
      wr_q        <= wr_n;
`ifdef BUS_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_n;
      err_q       <= err_n;
`endif
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.ALE       = ale_q;
  assign bus.A         = a_q;
  assign bus.AD_O      = ad_o_q;
  assign bus.AD_OE     = ad_oe_q;
  assign bus.IOM       = iom_q;
  assign bus.DTR       = dtr_q;
  assign bus.DEN       = den_q;
  assign bus.RD        = rd_q;
  assign bus.WR        = wr_q;
`ifdef BUS_TIMEOUT_EN
  assign bus.rsp_err   = err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_i8088_bus_master.sv
// Directed bench for i8088_bus_master with a small memory/I-O responder on the bus side.
module tb_i8088_bus_master;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  i8088_bus_master_if bus();
  i8088_bus_master #(.WAIT_LIMIT(15)) dut (.CLK(clk), .RESET(rst), .bus(bus));

  always #5 clk = ~clk;

  // Responder: latches the address on ALE, stores memory writes, answers I/O reads with 8'h5C.
  logic [7:0]  mem [256] = '{default: 8'h00};
  logic [19:0] lat_addr = '0;
  logic        lat_io = 1'b0;
  always @(negedge clk) begin
    if (bus.ALE) begin
      lat_addr <= {bus.A, bus.AD_O};
      lat_io   <= bus.IOM;
    end
    if (!bus.WR && !lat_io) mem[lat_addr[7:0]] <= bus.AD_O;
  end
  assign bus.AD_I = lat_io ? 8'h5C : mem[lat_addr[7:0]];

  localparam logic [37:0] RST_VEC = {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000, 8'h00,
                                     1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  function automatic logic [37:0] obs_all();
    return {bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.ALE, bus.A,
            bus.AD_O, bus.AD_OE, bus.IOM, bus.DTR, bus.DEN, bus.RD, bus.WR};
  endfunction

  // {ALE, AD_OE, IOM, DTR, DEN, RD, WR, req_ready, rsp_valid, rsp_err}
  function automatic logic [9:0] ctl();
    return {bus.ALE, bus.AD_OE, bus.IOM, bus.DTR, bus.DEN, bus.RD, bus.WR,
            bus.req_ready, bus.rsp_valid, bus.rsp_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic io, input logic [19:0] addr, input logic [7:0] wd);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_io    = io;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_chk++;
    if (obs_all() !== RST_VEC) begin
      n_fail++;
      $display("FAIL reset_held: got %h want %h", obs_all(), RST_VEC);
    end
    rst = 1'b0;
    tick();
    n_chk++;
    if (obs_all() !== RST_VEC) begin
      n_fail++;
      $display("FAIL reset_idle: got %h want %h", obs_all(), RST_VEC);
    end
  endtask

  task automatic test_mem_write();
    issue(1'b1, 1'b0, 20'h12345, 8'hA5);
    n_chk++;
    if (ctl() !== 10'b1101111000 || bus.A !== 12'h123 || bus.AD_O !== 8'h45) begin
      n_fail++;
      $display("FAIL write_t1: ctl=%b A=%h AD_O=%h want 1101111000/123/45", ctl(), bus.A, bus.AD_O);
    end
    for (int c = 2; c <= 3; c++) begin
      tick();
      n_chk++;
      if (ctl() !== 10'b0101010000 || bus.AD_O !== 8'hA5) begin
        n_fail++;
        $display("FAIL write_t%0d: ctl=%b AD_O=%h want 0101010000/a5", c, ctl(), bus.AD_O);
      end
    end
    tick();
    n_chk++;
    if (ctl() !== 10'b0001111110 || bus.A !== 12'h123) begin
      n_fail++;
      $display("FAIL write_t4: ctl=%b A=%h want 0001111110/123", ctl(), bus.A);
    end
    tick();
    n_chk++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || mem[8'h45] !== 8'hA5) begin
      n_fail++;
      $display("FAIL write_done: rdy=%b vld=%b mem=%h want 1/0/a5", bus.req_ready, bus.rsp_valid, mem[8'h45]);
    end
  endtask

  task automatic test_mem_read();
    issue(1'b0, 1'b0, 20'h12345, 8'h00);
    n_chk++;
    if (ctl() !== 10'b1100111000 || bus.A !== 12'h123 || bus.AD_O !== 8'h45) begin
      n_fail++;
      $display("FAIL read_t1: ctl=%b A=%h AD_O=%h want 1100111000/123/45", ctl(), bus.A, bus.AD_O);
    end
    for (int c = 2; c <= 3; c++) begin
      tick();
      n_chk++;
      if (ctl() !== 10'b0000001000) begin
        n_fail++;
        $display("FAIL read_t%0d: ctl=%b want 0000001000", c, ctl());
      end
    end
    tick();
    n_chk++;
    if (ctl() !== 10'b0000111110 || bus.rsp_rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL read_t4: ctl=%b rdata=%h want 0000111110/a5", ctl(), bus.rsp_rdata);
    end
    tick();
    n_chk++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL read_hold: vld=%b rdata=%h want 0/a5", bus.rsp_valid, bus.rsp_rdata);
    end
  endtask

  task automatic test_io_wait();
    int first;
    first = 0;
    bus.READY = 1'b0;
    issue(1'b0, 1'b1, 20'hAFF03, 8'h00);
    n_chk++;
    if (ctl() !== 10'b1110111000 || bus.A !== 12'h0FF || bus.AD_O !== 8'h03) begin
      n_fail++;
      $display("FAIL io_t1: ctl=%b A=%h AD_O=%h want 1110111000/0ff/03", ctl(), bus.A, bus.AD_O);
    end
    for (int c = 2; c <= 7; c++) begin
      tick();
      if (bus.rsp_valid && first == 0) first = c;
      if (c < 7) begin
        n_chk++;
        if (ctl() !== 10'b0010001000) begin
          n_fail++;
          $display("FAIL io_clk%0d: ctl=%b want 0010001000", c, ctl());
        end
      end
      if (c == 6) bus.READY = 1'b1;
    end
    n_chk++;
    if (first != 7 || ctl() !== 10'b0010111110 || bus.rsp_rdata !== 8'h5C) begin
      n_fail++;
      $display("FAIL io_done: first_vld=%0d ctl=%b rdata=%h want 7/0010111110/5c", first, ctl(), bus.rsp_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int vld_cnt;
    int ale_cnt;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_io    = 1'b0;
    bus.req_addr  = 20'h00210;
    bus.req_wdata = 8'h3C;
    tick();
    ale_cnt = int'(bus.ALE);
    vld_cnt = 0;
    bus.req_addr  = 20'h00211;
    bus.req_wdata = 8'h7E;
    for (int c = 2; c <= 8; c++) begin
      tick();
      ale_cnt += int'(bus.ALE);
      vld_cnt += int'(bus.rsp_valid);
      if (c == 5) begin
        n_chk++;
        if (bus.ALE !== 1'b1 || bus.A !== 12'h002 || bus.AD_O !== 8'h11) begin
          n_fail++;
          $display("FAIL b2b_t1: ALE=%b A=%h AD_O=%h want 1/002/11", bus.ALE, bus.A, bus.AD_O);
        end
        bus.req_valid = 1'b0;
      end
    end
    n_chk++;
    if (vld_cnt != 2 || ale_cnt != 2 || bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 8'h5C) begin
      n_fail++;
      $display("FAIL b2b_count: vld=%0d ale=%0d last_vld=%b rdata=%h want 2/2/1/5c",
               vld_cnt, ale_cnt, bus.rsp_valid, bus.rsp_rdata);
    end
    tick();
    n_chk++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || mem[8'h10] !== 8'h3C || mem[8'h11] !== 8'h7E) begin
      n_fail++;
      $display("FAIL b2b_done: rdy=%b vld=%b m10=%h m11=%h want 1/0/3c/7e",
               bus.req_ready, bus.rsp_valid, mem[8'h10], mem[8'h11]);
    end
  endtask

  task automatic test_reset_in_wait();
    bus.READY = 1'b0;
    issue(1'b0, 1'b0, 20'h12345, 8'h00);
    for (int c = 2; c <= 4; c++) tick();
    n_chk++;
    if (ctl() !== 10'b0000001000) begin
      n_fail++;
      $display("FAIL rstw_tw: ctl=%b want 0000001000", ctl());
    end
    rst = 1'b1;
    tick();
    n_chk++;
    if (obs_all() !== RST_VEC) begin
      n_fail++;
      $display("FAIL rstw_reset: got %h want %h", obs_all(), RST_VEC);
    end
    rst = 1'b0;
    bus.READY = 1'b1;
    tick();
    n_chk++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.RD !== 1'b1) begin
      n_fail++;
      $display("FAIL rstw_after: vld=%b rdy=%b RD=%b want 0/1/1", bus.rsp_valid, bus.req_ready, bus.RD);
    end
  endtask

  task automatic test_timeout();
`ifdef BUS_TIMEOUT_EN
    int first;
    first = 0;
    bus.READY = 1'b0;
    issue(1'b0, 1'b0, 20'h12345, 8'h00);
    for (int c = 2; c <= 19; c++) begin
      tick();
      if (bus.rsp_valid && first == 0) first = c;
    end
    n_chk++;
    if (first != 19 || bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 8'hFF) begin
      n_fail++;
      $display("FAIL timeout_t4: first_vld=%0d err=%b rdata=%h want 19/1/ff", first, bus.rsp_err, bus.rsp_rdata);
    end
    bus.READY = 1'b1;
    tick();
    issue(1'b0, 1'b0, 20'h12345, 8'h00);
    n_chk++;
    if (bus.rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear: err=%b want 0", bus.rsp_err);
    end
    for (int c = 2; c <= 4; c++) tick();
    n_chk++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 8'hA5) begin
      n_fail++;
      $display("FAIL timeout_next: vld=%b err=%b rdata=%h want 1/0/a5", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    tick();
`else
    int vcount;
    vcount = 0;
    bus.READY = 1'b0;
    issue(1'b0, 1'b0, 20'h12345, 8'h00);
    for (int c = 2; c <= 101; c++) begin
      tick();
      vcount += int'(bus.rsp_valid);
    end
    n_chk++;
    if (vcount != 0 || ctl() !== 10'b0000001000) begin
      n_fail++;
      $display("FAIL unbounded_wait: vld_pulses=%0d ctl=%b want 0/0000001000", vcount, ctl());
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.READY = 1'b1;
    tick();
`endif
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_io    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.READY     = 1'b1;
    tick();
    tick();
    test_reset();
    test_mem_write();
    test_mem_read();
    test_io_wait();
    test_back_to_back();
    test_reset_in_wait();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
